// File: rtl/mic_level_freq_meter.sv
// rtl/mic_level_freq_meter.sv - microphone peak-hold level meter, LED bar, clip flag and zero-crossing frequency counter
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   mic         24-bit two's-complement sample, held between sample updates
//   clear       clears the sticky clip flag (a simultaneous clip event wins)
//   level       16-bit level: attack at window end, linear release of decay per window
//   led         thermometer bar derived from level, one cycle behind level
//   clip        sticky full-scale indicator
//   freq        rising crossings counted in the last complete gate
//   freq_valid  set once the first gate has completed
//   window_tick one-cycle pulse on the last cycle of each window
module mic_level_freq_meter #(
    parameter int clk_mhz   = 50,
    parameter int w_led     = 4,
    parameter int window_ms = 10,
    parameter int gate_ms   = 1000,
    parameter int decay     = 1024,
    parameter int hyst      = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      mic,
    input  logic             clear,
    output logic [15:0]      level,
    output logic [w_led-1:0] led,
    output logic             clip,
    output logic [15:0]      freq,
    output logic             freq_valid,
    output logic             window_tick
);

    localparam int WIN_CYC  = clk_mhz * 1000 * window_ms;
    localparam int GATE_CYC = clk_mhz * 1000 * gate_ms;
    localparam int WW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int GW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_CYC - 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYC - 1);
    localparam logic [15:0] DECAY = 16'(decay);
    localparam logic signed [23:0] HYST_P = 24'(hyst);
    localparam logic signed [23:0] HYST_N = -HYST_P;

    typedef enum logic [1:0] {UNK, POS, NEG} cross_state_t;

    // Magnitude: -(-2^23) does not fit in 23 bits, so it saturates.
    logic [23:0] mic_neg;
    logic [22:0] mag;
    logic [15:0] mag16;
    logic        mag_lsbs_unused;

    assign mic_neg = -mic;
    assign mag = !mic[23] ? mic[22:0] : (mic_neg[23] ? 23'h7FFFFF : mic_neg[22:0]);
    assign mag16 = mag[22:7];
    assign mag_lsbs_unused = ^mag[6:0];

    // Window timing and peak/level tracking
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          wcnt_end;
    logic [15:0]   peak, pk, decayed, level_nxt;

    assign wcnt_end  = (wcnt == WIN_LAST);
    assign wcnt_nxt  = wcnt_end ? '0 : wcnt + WW'(1);
    // The tick-cycle sample is folded into pk so it is not lost when peak clears.
    assign pk        = (mag16 > peak) ? mag16 : peak;
    assign decayed   = (level >= DECAY) ? level - DECAY : 16'd0;
    assign level_nxt = (pk > decayed) ? pk : decayed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt        <= '0;
            window_tick <= 1'b0;
            peak        <= '0;
            level       <= '0;
        end else begin
            wcnt        <= wcnt_nxt;
            // Registered so the pulse coincides with the counter sitting on its last value.
            window_tick <= (wcnt_nxt == WIN_LAST);
            if (wcnt_end) begin
                level <= level_nxt;
                peak  <= '0;
            end else begin
                peak  <= pk;
            end
        end
    end

    // LED bar and clip flag
    logic clip_set;
    assign clip_set = (mic == 24'h7FFFFF) || (mic == 24'h800000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led  <= '0;
            clip <= 1'b0;
        end else begin
            for (int i = 0; i < w_led; i++) begin
                led[i] <= ({16'd0, level} >= 32'(((i + 1) * 65536) / (w_led + 1)));
            end
            if (clip_set) begin
                clip <= 1'b1;
            end else if (clear) begin
                clip <= 1'b0;
            end
        end
    end

    // Hysteresis crossing detector
    cross_state_t        state, state_nxt;
    logic                rise;
    logic signed [23:0]  mic_s;
    logic                is_hi, is_lo;

    assign mic_s = $signed(mic);
    assign is_hi = (mic_s >= HYST_P);
    assign is_lo = (mic_s <= HYST_N);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rise      = 1'b0;
        case (state)
            UNK: begin
                if (is_hi) begin
                    state_nxt = POS;
                end else if (is_lo) begin
                    state_nxt = NEG;
                end
            end
            POS: begin
                if (is_lo) begin
                    state_nxt = NEG;
                end
            end
            NEG: begin
                if (is_hi) begin
                    state_nxt = POS;
                    rise      = 1'b1;
                end
            end
            default: state_nxt = UNK;
        endcase
    end

    // Gate timing and crossing count
    logic [GW-1:0] gcnt;
    logic          gate_end;
    logic [15:0]   cross_cnt, cnt_inc;

    assign gate_end = (gcnt == GATE_LAST);
    assign cnt_inc  = (rise && cross_cnt != 16'hFFFF) ? cross_cnt + 16'd1 : cross_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt       <= '0;
            cross_cnt  <= '0;
            freq       <= '0;
            freq_valid <= 1'b0;
        end else begin
            if (gate_end) begin
                gcnt       <= '0;
                freq       <= cnt_inc;
                cross_cnt  <= '0;
                freq_valid <= 1'b1;
            end else begin
                gcnt       <= gcnt + GW'(1);
                cross_cnt  <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_mic_level_freq_meter.sv
// tb/tb_mic_level_freq_meter.sv - self-checking bench for mic_level_freq_meter
module tb_mic_level_freq_meter;

    localparam int W_LED = 4;
    localparam int WIN   = 1000;
    localparam int GATE  = 10000;
    localparam int DECAY = 1024;
    localparam int HYST  = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic [23:0]      mic;
    logic             clear;
    logic [15:0]      level;
    logic [W_LED-1:0] led;
    logic             clip;
    logic [15:0]      freq;
    logic             freq_valid;
    logic             window_tick;

    always #5 clk = ~clk;

    mic_level_freq_meter #(
        .clk_mhz(1), .w_led(W_LED), .window_ms(1), .gate_ms(10), .decay(DECAY), .hyst(HYST)
    ) dut (
        .clk(clk), .rst(rst), .mic(mic), .clear(clear), .level(level), .led(led),
        .clip(clip), .freq(freq), .freq_valid(freq_valid), .window_tick(window_tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: m_k counts clock edges since reset release.
    int               m_k, m_level, m_peak, m_clip, m_sign, m_cross, m_freq, m_fvalid, m_tick;
    logic [W_LED-1:0] m_led;

    function automatic logic [W_LED-1:0] led_of(input int lv);
        logic [W_LED-1:0] r;
        for (int i = 0; i < W_LED; i++) r[i] = (lv >= ((i + 1) * 65536) / (W_LED + 1));
        return r;
    endfunction

    task automatic model_reset();
        m_k = 0; m_level = 0; m_peak = 0; m_clip = 0; m_sign = 0;
        m_cross = 0; m_freq = 0; m_fvalid = 0; m_tick = 0; m_led = '0;
    endtask

    // Drive inputs for one edge, advance the model, then sit 1 time unit past the edge.
    task automatic step(input logic [23:0] v, input logic c);
        int s, mg, rise_now;
        mic = v;
        clear = c;
        @(posedge clk);
        s  = v[23] ? int'(v) - 16777216 : int'(v);
        mg = (s < 0) ? -s : s;
        if (mg > 8388607) mg = 8388607;
        m_k++;
        m_led = led_of(m_level);
        if (mg / 128 > m_peak) m_peak = mg / 128;
        if (m_k % WIN == 0) begin
            m_level = (m_level >= DECAY) ? m_level - DECAY : 0;
            if (m_peak > m_level) m_level = m_peak;
            m_peak = 0;
        end
        m_tick = ((m_k + 1) % WIN == 0);
        if (v == 24'h7FFFFF || v == 24'h800000) m_clip = 1;
        else if (c) m_clip = 0;
        rise_now = 0;
        if (s >= HYST) begin
            if (m_sign == -1) rise_now = 1;
            m_sign = 1;
        end else if (s <= -HYST) begin
            m_sign = -1;
        end
        m_cross = m_cross + rise_now;
        if (m_cross > 65535) m_cross = 65535;
        if (m_k % GATE == 0) begin
            m_freq = m_cross;
            m_cross = 0;
            m_fvalid = 1;
        end
        #1;
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        mic = '0;
        clear = 1'b0;
        assert_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (level !== 16'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (led !== '0) begin errors++; $display("FAIL reset_led got %b exp 0", led); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip got %b exp 0", clip); end
        checks++; if (freq !== 16'd0) begin errors++; $display("FAIL reset_freq got %0d exp 0", freq); end
        checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid got %b exp 0", freq_valid); end
        checks++; if (window_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", window_tick); end
        release_reset();
    endtask

    task automatic test_attack();
        for (int e = 1; e <= WIN + 1; e++) begin
            step(24'h400000, 1'b0);
            checks++;
            if (window_tick !== 1'(m_tick)) begin
                errors++; $display("FAIL attack_tick k=%0d got %b exp %0d", m_k, window_tick, m_tick);
            end
            if (e == WIN - 1) begin
                checks++; if (window_tick !== 1'b1) begin errors++; $display("FAIL attack_tick999 got %b exp 1", window_tick); end
            end
            if (e == WIN) begin
                checks++; if (level !== 16'd32768) begin errors++; $display("FAIL attack_level got %0d exp 32768", level); end
            end
        end
        checks++; if (led !== 4'b0011) begin errors++; $display("FAIL attack_led got %b exp 0011", led); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL attack_clip got %b exp 0", clip); end
    endtask

    task automatic test_release();
        for (int e = 0; e < 33 * WIN; e++) begin
            step(24'h000000, 1'b0);
            if (m_k % WIN == 0) begin
                checks++;
                if (level !== 16'(m_level)) begin errors++; $display("FAIL release_level k=%0d got %0d exp %0d", m_k, level, m_level); end
            end
            if (m_k % WIN == 1) begin
                checks++;
                if (led !== m_led) begin errors++; $display("FAIL release_led k=%0d got %b exp %b", m_k, led, m_led); end
            end
        end
        checks++; if (level !== 16'd0) begin errors++; $display("FAIL release_floor got %0d exp 0", level); end
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL release_led_off got %b exp 0000", led); end
    endtask

    task automatic test_clip();
        for (int e = 0; e < 5; e++) begin
            step(24'h800000, 1'b0);
            checks++; if (clip !== 1'b1) begin errors++; $display("FAIL clip_set got %b exp 1", clip); end
        end
        step(24'h800000, 1'b1);
        checks++; if (clip !== 1'b1) begin errors++; $display("FAIL clip_set_wins got %b exp 1", clip); end
        step(24'h000000, 1'b1);
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL clip_clear got %b exp 0", clip); end
        for (int e = 0; e < WIN && (m_k % WIN != 0); e++) step(24'h000000, 1'b0);
        checks++; if (level !== 16'd65535) begin errors++; $display("FAIL clip_level got %0d exp 65535", level); end
        step(24'h000000, 1'b0);
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL clip_led got %b exp 1111", led); end
    endtask

    task automatic test_freq();
        int amp;
        amp = $urandom_range(HYST, 24'h3FFFFF);
        assert_reset();
        release_reset();
        for (int e = 0; e < 2 * GATE + 10; e++) begin
            step(((e % 100) < 50) ? 24'(-amp) : 24'(amp), 1'b0);
            if (m_k % GATE == 0 || m_k == GATE + GATE / 2) begin
                checks++;
                if (freq !== 16'(m_freq)) begin errors++; $display("FAIL freq_model k=%0d got %0d exp %0d", m_k, freq, m_freq); end
                checks++;
                if (freq_valid !== 1'b1) begin errors++; $display("FAIL freq_valid k=%0d got %b exp 1", m_k, freq_valid); end
            end
            if (m_k == GATE) begin
                checks++;
                if (freq != 16'd99 && freq != 16'd100) begin errors++; $display("FAIL freq_first got %0d exp 99 or 100", freq); end
            end
            if (m_k == GATE - 1) begin
                checks++;
                if (freq_valid !== 1'b0) begin errors++; $display("FAIL freq_valid_early got %b exp 0", freq_valid); end
            end
        end
        checks++; if (freq !== 16'd100) begin errors++; $display("FAIL freq_second got %0d exp 100", freq); end
    endtask

    task automatic test_reset_mid();
        while (m_k % WIN != 500) step(24'h400000, 1'b0);
        assert_reset();
        checks++; if (level !== 16'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
        checks++; if (led !== '0) begin errors++; $display("FAIL mid_led got %b exp 0", led); end
        checks++; if (freq !== 16'd0) begin errors++; $display("FAIL mid_freq got %0d exp 0", freq); end
        checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL mid_fvalid got %b exp 0", freq_valid); end
        checks++; if (window_tick !== 1'b0) begin errors++; $display("FAIL mid_tick got %b exp 0", window_tick); end
        mic = 24'h400000;
        release_reset();
        for (int e = 1; e <= WIN; e++) begin
            step(24'h400000, 1'b0);
            checks++;
            if (window_tick !== 1'(m_tick)) begin errors++; $display("FAIL mid_tick_seq k=%0d got %b exp %0d", m_k, window_tick, m_tick); end
        end
        checks++; if (level !== 16'd32768) begin errors++; $display("FAIL mid_level_after got %0d exp 32768", level); end
    endtask

    task automatic test_small();
        int amp, half;
        amp  = $urandom_range(1, HYST - 1);
        half = $urandom_range(2, 100);
        assert_reset();
        release_reset();
        for (int e = 0; e < GATE; e++) begin
            if (e == GATE / 2) step(24'h001000, 1'b0);
            else step(((e / half) % 2 == 0) ? 24'(-amp) : 24'(amp), 1'b0);
        end
        checks++; if (freq !== 16'd0) begin errors++; $display("FAIL small_freq got %0d exp 0", freq); end
        checks++; if (freq !== 16'(m_freq)) begin errors++; $display("FAIL small_model got %0d exp %0d", freq, m_freq); end
        checks++; if (freq_valid !== 1'b1) begin errors++; $display("FAIL small_fvalid got %b exp 1", freq_valid); end
    endtask

    task automatic test_random();
        logic [23:0] v;
        int          hold;
        assert_reset();
        release_reset();
        hold = 0;
        v = '0;
        for (int e = 0; e < 2500; e++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 7))
                    0: v = 24'h7FFFFF;
                    1: v = 24'h800000;
                    2: v = 24'(HYST + $urandom_range(0, 2) - 1);
                    3: v = 24'(-HYST + $urandom_range(0, 2) - 1);
                    default: v = 24'($urandom);
                endcase
                hold = $urandom_range(1, 20);
            end
            hold--;
            step(v, ($urandom_range(0, 7) == 0));
            checks++; if (level !== 16'(m_level)) begin errors++; $display("FAIL rand_level k=%0d got %0d exp %0d", m_k, level, m_level); end
            checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led k=%0d got %b exp %b", m_k, led, m_led); end
            checks++; if (clip !== 1'(m_clip)) begin errors++; $display("FAIL rand_clip k=%0d got %b exp %0d", m_k, clip, m_clip); end
            checks++; if (window_tick !== 1'(m_tick)) begin errors++; $display("FAIL rand_tick k=%0d got %b exp %0d", m_k, window_tick, m_tick); end
            checks++; if (freq !== 16'(m_freq)) begin errors++; $display("FAIL rand_freq k=%0d got %0d exp %0d", m_k, freq, m_freq); end
            checks++; if (freq_valid !== 1'(m_fvalid)) begin errors++; $display("FAIL rand_fvalid k=%0d got %b exp %0d", m_k, freq_valid, m_fvalid); end
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_release();
        test_clip();
        test_freq();
        test_reset_mid();
        test_small();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
